rr_input_buffer: RTL and testbench
==================================

// Module: rr_input_buffer
// PURPOSE
// - Dual-ported instruction FIFO between the decode stage (ID) and register renaming (RR).
// - Decouples decode from rename stalls caused by free-list, ROB or issue back-pressure.
// - Accepts up to 2 decoded instructions/cycle in program order and presents the 2 oldest to RR.
// - RR consumes both presented entries together when it asserts ready_i. Flush empties the buffer.
// PARAMETERS
// - DATA_W  128  width of one packed decoded_instr entry
// - DEPTH   8    entries; power of 2, >= 4
// PORTS
// - clk          in   1       clock; all state updates on posedge
// - rst          in   1       synchronous, active-high reset
// - flush_valid  in   1       pipeline flush; discards all buffered and incoming entries
// - valid_i_1    in   1       upstream slot 1 valid (older)
// - data_i_1     in   DATA_W  upstream slot 1 instruction
// - valid_i_2    in   1       upstream slot 2 valid (younger)
// - data_i_2     in   DATA_W  upstream slot 2 instruction
// - ready_o      out  1       buffer can take 2 entries this cycle
// - valid_o_1    out  1       oldest entry present
// - data_o_1     out  DATA_W  oldest entry
// - valid_o_2    out  1       second-oldest entry present
// - data_o_2     out  DATA_W  second-oldest entry
// - ready_i      in   1       RR consumes every currently valid output entry
// - stall_cnt    out  32      ID-side stall cycles (only with RR_BUF_STATS_EN)
// BEHAVIOUR
// - State: mem[DEPTH], head/tail pointers ($clog2(DEPTH) bits, natural wrap), count ($clog2(DEPTH)+1 bits).
// - Reset: head=tail=count=0, valid_o_1=valid_o_2=0, ready_o=1, stall_cnt=0. mem is not reset.
// - Outputs are combinational from registered state:
//   - ready_o   = (DEPTH-count) >= 2; it does not depend on same-cycle pops, so ID->RR has no comb path.
//   - valid_o_1 = count>=1; valid_o_2 = count>=2.
//   - data_o_1 = mem[head]; data_o_2 = mem[head+1] (mod DEPTH).
//   - data_o_* is undefined while the matching valid_o_* is low.
// - Push (only when ready_o & ~flush_valid):
//   - valid_i_1 & valid_i_2: data_i_1 -> mem[tail], data_i_2 -> mem[tail+1]; tail += 2.
//   - Exactly one valid: that entry -> mem[tail]; tail += 1 (compaction; order preserved).
//   - ready_o low: inputs ignored. ID must hold them.
// - Pop (when ready_i & ~flush_valid): pops = valid_o_1 + valid_o_2; head += pops.
// - Push and pop in the same cycle: count_next = count + pushes - pops. No overflow is possible.
// - Latency: an entry pushed in cycle N is visible at the outputs in cycle N+1. There is no bypass.
// - Flush has priority over push and pop:
//   - head=tail=count=0; same-cycle inputs are dropped.
//   - valid_o_* = 0 and ready_o = 1 from cycle N+1.
// - Wrap-around: pointer increments are modulo DEPTH; head+1 wraps for data_o_2.
// - Full: count=DEPTH-1 or DEPTH gives ready_o=0. Empty: count=0 gives both valid_o low; ready_i is a don't-care.
// - Reset asserted mid-operation: identical to the reset state on the next edge, regardless of flush or push.
// CONFIGURATION
// - RR_BUF_STATS_EN defined:
//   - stall_cnt increments (saturating at 2^32-1) each cycle with valid_i_1 & ~ready_o & ~flush_valid.
//   - stall_cnt clears only on rst.
// - RR_BUF_STATS_EN undefined: stall_cnt tied to 0 and no counter flops are inferred.
// TESTING
// - Reset, then push 2/cycle for 3 cycles with ready_i=0 -> count=6, ready_o=1.
//   A 4th push makes count=8 and ready_o=0.
// - Buffer holding A,B,C; ready_i=1 -> A,B popped; next cycle valid_o_1=1 with data_o_1=C, valid_o_2=0.
// - count=4 with head=6 (wrapped); simultaneous push of 2 and pop of 2 -> count stays 4.
//   data_o_1=mem[0], data_o_2=mem[1], tail=4.
// - Buffer holding 5 entries; flush_valid=1 with a valid push -> next cycle count=0, valid_o_*=0, ready_o=1.
// - Push valid_i_2 only (valid_i_1=0) into an empty buffer -> next cycle valid_o_1=1, data_o_1=data_i_2, valid_o_2=0.
// - RR_BUF_STATS_EN: hold the buffer full with valid_i_1=1 for 10 cycles -> stall_cnt=10.
//   rst -> stall_cnt=0.

Source files
------------

// File: rtl/rr_input_buffer.sv
`default_nettype none
// ============================================================================
// Module   : rr_input_buffer
// Purpose  : Dual-ported, in-order instruction FIFO between decode (ID) and
//            register renaming (RR). Up to two entries are written per cycle,
//            and the two oldest entries are presented to RR. RR pops every
//            presented valid entry when ready_i is high. A flush empties the
//            buffer.
// Options  : RR_BUF_STATS_EN - enables the saturating ID-side stall counter
//            on stall_cnt. When it is undefined, stall_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module rr_input_buffer #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_valid,
  input  logic              valid_i_1,
  input  logic [DATA_W-1:0] data_i_1,
  input  logic              valid_i_2,
  input  logic [DATA_W-1:0] data_i_2,
  output logic              ready_o,
  output logic              valid_o_1,
  output logic [DATA_W-1:0] data_o_1,
  output logic              valid_o_2,
  output logic [DATA_W-1:0] data_o_2,
  input  logic              ready_i,
  output logic [31:0]       stall_cnt
);

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;
  // ready_o is high while at least two slots are free.
  localparam logic [C_CNT_W-1:0] C_READY_MAX = C_CNT_W'(DEPTH - 2);

  // Storage is deliberately not reset; count_q alone qualifies its contents.
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [C_PTR_W-1:0] head_q, head_d;
  logic [C_PTR_W-1:0] tail_q, tail_d;
  logic [C_CNT_W-1:0] count_q, count_d;

  logic               w_push_en;
  logic               w_pop_en;
  logic [1:0]         w_push_num;
  logic [1:0]         w_pop_num;
  logic [C_PTR_W-1:0] w_head_nxt1;
  logic [C_PTR_W-1:0] w_tail_nxt1;
  logic [DATA_W-1:0]  w_wr_data_0;

  // Outputs come only from registered state. ready_o ignores same-cycle
  // pops, so there is no combinational path from ready_i to ready_o.
  assign ready_o   = (count_q <= C_READY_MAX);
  assign valid_o_1 = (count_q != '0);
  assign valid_o_2 = (count_q >= C_CNT_W'(2));

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  assign w_head_nxt1 = head_q + C_PTR_W'(1);
  assign w_tail_nxt1 = tail_q + C_PTR_W'(1);
  assign data_o_1    = mem_q[head_q];
  assign data_o_2    = mem_q[w_head_nxt1];

  // Flush overrides both directions. Pushes are gated only by registered
  // ready_o, which is safe because two free slots are always guaranteed.
  assign w_push_en  = ready_o & ~flush_valid;
  assign w_pop_en   = ready_i & ~flush_valid;
  assign w_push_num = w_push_en ? ({1'b0, valid_i_1} + {1'b0, valid_i_2}) : 2'd0;
  assign w_pop_num  = w_pop_en  ? ({1'b0, valid_o_1} + {1'b0, valid_o_2}) : 2'd0;

  // Compaction: a lone slot-2 instruction still lands at the tail.
  assign w_wr_data_0 = valid_i_1 ? data_i_1 : data_i_2;

  // Next-state pointers and occupancy; flush returns to the empty state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + C_PTR_W'(w_pop_num);
      tail_d  = tail_q + C_PTR_W'(w_push_num);
      count_d = count_q + C_CNT_W'(w_push_num) - C_CNT_W'(w_pop_num);
    end
  end

  // Pointer and count registers; reset has priority over flush and push.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage writes. A write during reset is harmless because count_q
  // is cleared in the same cycle, which leaves the slot invalid.
  always_ff @(posedge clk) begin
    if (w_push_num != 2'd0) begin
      mem_q[tail_q] <= w_wr_data_0;
    end
    if (w_push_num == 2'd2) begin
      mem_q[w_tail_nxt1] <= data_i_2;
    end
  end

`ifdef RR_BUF_STATS_EN
  logic [31:0] stall_cnt_q;

  // Count cycles where ID offers an instruction but the buffer refuses it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (valid_i_1 & ~ready_o & ~flush_valid & (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_input_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_input_buffer
// Purpose  : Self-checking bench for rr_input_buffer. A queue-based reference
//            model tracks the in-order contents and the stall count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_input_buffer;

  localparam int DATA_W = 128;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush_valid = 1'b0;
  logic              valid_i_1 = 1'b0;
  logic [DATA_W-1:0] data_i_1 = '0;
  logic              valid_i_2 = 1'b0;
  logic [DATA_W-1:0] data_i_2 = '0;
  logic              ready_o;
  logic              valid_o_1;
  logic [DATA_W-1:0] data_o_1;
  logic              valid_o_2;
  logic [DATA_W-1:0] data_o_2;
  logic              ready_i = 1'b0;
  logic [31:0]       stall_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: the buffer contents, oldest entry first.
  logic [DATA_W-1:0] model_q[$];
  logic [31:0]       exp_stall = '0;

  rr_input_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_valid(flush_valid),
    .valid_i_1  (valid_i_1),
    .data_i_1   (data_i_1),
    .valid_i_2  (valid_i_2),
    .data_i_2   (data_i_2),
    .ready_o    (ready_o),
    .valid_o_1  (valid_o_1),
    .data_o_1   (data_o_1),
    .valid_o_2  (valid_o_2),
    .data_o_2   (data_o_2),
    .ready_i    (ready_i),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one cycle of inputs, advance the model, and land 1ns after the edge.
  task automatic step(input logic v1, input logic [DATA_W-1:0] d1,
                      input logic v2, input logic [DATA_W-1:0] d2,
                      input logic rdy, input logic fl, input logic rs);
    int n;
    bit room;
    rst = rs; flush_valid = fl; ready_i = rdy;
    valid_i_1 = v1; data_i_1 = d1; valid_i_2 = v2; data_i_2 = d2;
    room = (DEPTH - model_q.size()) >= 2;
    if (rs) begin
      model_q.delete();
      exp_stall = '0;
    end else begin
`ifdef RR_BUF_STATS_EN
      if (v1 && !room && !fl && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 1;
`endif
      if (fl) begin
        model_q.delete();
      end else begin
        if (rdy) begin
          n = (model_q.size() > 2) ? 2 : model_q.size();
          repeat (n) void'(model_q.pop_front());
        end
        if (room) begin
          if (v1) model_q.push_back(d1);
          if (v2) model_q.push_back(d2);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reset();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    step(1'b1, rand_word(), 1'b1, rand_word(), 1'b1, 1'b0, 1'b1);
    step(1'b1, rand_word(), 1'b0, rand_word(), 1'b0, 1'b1, 1'b1);
    total++; if (ready_o !== 1'b1)   begin bad++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    total++; if (valid_o_1 !== 1'b0) begin bad++; $display("FAIL reset_valid1: got %b want 0", valid_o_1); end
    total++; if (valid_o_2 !== 1'b0) begin bad++; $display("FAIL reset_valid2: got %b want 0", valid_o_2); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_fill();
    logic [DATA_W-1:0] w [10];
    idle_reset();
    foreach (w[i]) w[i] = rand_word();
    for (int i = 0; i < 3; i++) step(1'b1, w[2*i], 1'b1, w[2*i+1], 1'b0, 1'b0, 1'b0);
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL fill6_ready: got %b want 1", ready_o); end
    total++; if (valid_o_2 !== 1'b1 || data_o_1 !== w[0] || data_o_2 !== w[1]) begin
      bad++; $display("FAIL fill6_head: got v2=%b d1=%h d2=%h want v2=1 d1=%h d2=%h", valid_o_2, data_o_1, data_o_2, w[0], w[1]);
    end
    step(1'b1, w[6], 1'b1, w[7], 1'b0, 1'b0, 1'b0);
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL fill8_ready: got %b want 0", ready_o); end
    // Offer more while full; these must be ignored.
    step(1'b1, w[8], 1'b1, w[9], 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total++; if (valid_o_1 !== 1'b1 || valid_o_2 !== 1'b1 || data_o_1 !== w[2*i] || data_o_2 !== w[2*i+1]) begin
        bad++; $display("FAIL drain_%0d: got v=%b%b d1=%h d2=%h want v=11 d1=%h d2=%h", i, valid_o_1, valid_o_2, data_o_1, data_o_2, w[2*i], w[2*i+1]);
      end
      step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    total++; if (valid_o_1 !== 1'b0 || ready_o !== 1'b1) begin
      bad++; $display("FAIL drain_empty: got v1=%b rdy=%b want v1=0 rdy=1", valid_o_1, ready_o);
    end
  endtask

  task automatic test_partial_pop();
    logic [DATA_W-1:0] a, b, c;
    idle_reset();
    a = rand_word(); b = rand_word(); c = rand_word();
    step(1'b1, a, 1'b1, b, 1'b0, 1'b0, 1'b0);
    step(1'b1, c, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    total++; if (valid_o_1 !== 1'b1 || data_o_1 !== c || valid_o_2 !== 1'b0) begin
      bad++; $display("FAIL partial_pop: got v1=%b d1=%h v2=%b want v1=1 d1=%h v2=0", valid_o_1, data_o_1, valid_o_2, c);
    end
  endtask

  task automatic test_wrap();
    logic [DATA_W-1:0] e [6];
    idle_reset();
    for (int i = 0; i < 3; i++) step(1'b1, rand_word(), 1'b1, rand_word(), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    foreach (e[i]) e[i] = rand_word();
    step(1'b1, e[0], 1'b1, e[1], 1'b0, 1'b0, 1'b0);
    step(1'b1, e[2], 1'b1, e[3], 1'b0, 1'b0, 1'b0);
    total++; if (data_o_1 !== e[0] || data_o_2 !== e[1]) begin
      bad++; $display("FAIL wrap_head6: got d1=%h d2=%h want d1=%h d2=%h", data_o_1, data_o_2, e[0], e[1]);
    end
    step(1'b1, e[4], 1'b1, e[5], 1'b1, 1'b0, 1'b0);
    total++; if (ready_o !== 1'b1 || valid_o_2 !== 1'b1 || data_o_1 !== e[2] || data_o_2 !== e[3]) begin
      bad++; $display("FAIL wrap_pushpop: got rdy=%b v2=%b d1=%h d2=%h want rdy=1 v2=1 d1=%h d2=%h", ready_o, valid_o_2, data_o_1, data_o_2, e[2], e[3]);
    end
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    total++; if (valid_o_2 !== 1'b1 || data_o_1 !== e[4] || data_o_2 !== e[5]) begin
      bad++; $display("FAIL wrap_tail: got v2=%b d1=%h d2=%h want v2=1 d1=%h d2=%h", valid_o_2, data_o_1, data_o_2, e[4], e[5]);
    end
  endtask

  task automatic test_flush();
    logic [DATA_W-1:0] x;
    idle_reset();
    step(1'b1, rand_word(), 1'b1, rand_word(), 1'b0, 1'b0, 1'b0);
    step(1'b1, rand_word(), 1'b1, rand_word(), 1'b0, 1'b0, 1'b0);
    step(1'b1, rand_word(), 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, rand_word(), 1'b1, rand_word(), 1'b1, 1'b1, 1'b0);
    total++; if (valid_o_1 !== 1'b0 || valid_o_2 !== 1'b0 || ready_o !== 1'b1) begin
      bad++; $display("FAIL flush: got v=%b%b rdy=%b want v=00 rdy=1", valid_o_1, valid_o_2, ready_o);
    end
    x = rand_word();
    step(1'b1, x, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    total++; if (valid_o_1 !== 1'b1 || data_o_1 !== x || valid_o_2 !== 1'b0) begin
      bad++; $display("FAIL flush_refill: got v1=%b d1=%h v2=%b want v1=1 d1=%h v2=0", valid_o_1, data_o_1, valid_o_2, x);
    end
  endtask

  task automatic test_slot2_only();
    logic [DATA_W-1:0] d;
    idle_reset();
    d = rand_word();
    step(1'b0, rand_word(), 1'b1, d, 1'b0, 1'b0, 1'b0);
    total++; if (valid_o_1 !== 1'b1 || data_o_1 !== d || valid_o_2 !== 1'b0) begin
      bad++; $display("FAIL slot2_only: got v1=%b d1=%h v2=%b want v1=1 d1=%h v2=0", valid_o_1, data_o_1, valid_o_2, d);
    end
  endtask

  task automatic test_midreset();
    idle_reset();
    step(1'b1, rand_word(), 1'b1, rand_word(), 1'b0, 1'b0, 1'b0);
    step(1'b1, rand_word(), 1'b1, rand_word(), 1'b0, 1'b0, 1'b0);
    step(1'b1, rand_word(), 1'b1, rand_word(), 1'b0, 1'b0, 1'b1);
    total++; if (valid_o_1 !== 1'b0 || valid_o_2 !== 1'b0 || ready_o !== 1'b1) begin
      bad++; $display("FAIL midreset: got v=%b%b rdy=%b want v=00 rdy=1", valid_o_1, valid_o_2, ready_o);
    end
  endtask

  task automatic test_stats();
    idle_reset();
    for (int i = 0; i < 4; i++) step(1'b1, rand_word(), 1'b1, rand_word(), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, rand_word(), 1'b0, '0, 1'b0, 1'b0, 1'b0);
    total++; if (stall_cnt !== exp_stall) begin
      bad++; $display("FAIL stall_hold: got %0d want %0d", stall_cnt, exp_stall);
    end
`ifdef RR_BUF_STATS_EN
    total++; if (stall_cnt !== 32'd10) begin bad++; $display("FAIL stall_ten: got %0d want 10", stall_cnt); end
`endif
    // Flush while full must not count as a stall.
    step(1'b1, rand_word(), 1'b0, '0, 1'b0, 1'b1, 1'b0);
    total++; if (stall_cnt !== exp_stall) begin
      bad++; $display("FAIL stall_flush: got %0d want %0d", stall_cnt, exp_stall);
    end
    idle_reset();
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL stall_rst: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_random();
    logic v1, v2, rdy, fl;
    idle_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      v1  = ($urandom_range(99) < 70);
      v2  = ($urandom_range(99) < 60);
      rdy = ($urandom_range(99) < 35);
      fl  = ($urandom_range(99) < 4);
      step(v1, rand_word(), v2, rand_word(), rdy, fl, 1'b0);
      total++; if (ready_o !== ((DEPTH - model_q.size()) >= 2)) begin
        bad++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, ready_o, (DEPTH - model_q.size()) >= 2);
      end
      total++; if (valid_o_1 !== (model_q.size() >= 1) || valid_o_2 !== (model_q.size() >= 2)) begin
        bad++; $display("FAIL rand_valid@%0d: got %b%b want count %0d", cyc, valid_o_1, valid_o_2, model_q.size());
      end
      if (model_q.size() >= 1) begin
        total++; if (data_o_1 !== model_q[0]) begin
          bad++; $display("FAIL rand_data1@%0d: got %h want %h", cyc, data_o_1, model_q[0]);
        end
      end
      if (model_q.size() >= 2) begin
        total++; if (data_o_2 !== model_q[1]) begin
          bad++; $display("FAIL rand_data2@%0d: got %h want %h", cyc, data_o_2, model_q[1]);
        end
      end
      total++; if (stall_cnt !== exp_stall) begin
        bad++; $display("FAIL rand_stall@%0d: got %0d want %0d", cyc, stall_cnt, exp_stall);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_partial_pop();
    test_wrap();
    test_flush();
    test_slot2_only();
    test_midreset();
    test_stats();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
